// File: rtl/nn_classifier_layer.sv
// Fully-connected classifier output layer: streams NUM_IN features into NUM_OUT parallel MAC lanes,
// then adds bias, rescales, saturates, optionally applies ReLU and reports the argmax class.
module nn_classifier_layer #(
  parameter int DATA_W  = 16,
  parameter int FRAC_W  = 10,
  parameter int NUM_IN  = 9,
  parameter int NUM_OUT = 2,
  parameter int ACC_W   = 40,
  parameter int CLS_W   = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      start_i,
  input  logic [NUM_OUT*DATA_W-1:0] bias_i,
  input  logic                      relu_en_i,
  input  logic                      x_valid_i,
  output logic                      x_ready_o,
  input  logic [DATA_W-1:0]         x_data_i,
  input  logic [NUM_OUT*DATA_W-1:0] w_data_i,
  output logic                      y_valid_o,
  input  logic                      y_ready_i,
  output logic [NUM_OUT*DATA_W-1:0] y_data_o,
  output logic [CLS_W-1:0]          class_id_o,
  output logic                      busy_o
);

  localparam int CNT_W  = $clog2(NUM_IN + 1);
  localparam int PROD_W = 2 * DATA_W;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_FINAL, S_OUTPUT} state_e;

  state_e                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic signed [ACC_W-1:0]     acc_q [NUM_OUT];
  logic signed [ACC_W-1:0]     acc_d [NUM_OUT];
  logic [NUM_OUT*DATA_W-1:0]   bias_q, bias_d;
  logic                        reluEn_q, reluEn_d;
  logic [NUM_OUT*DATA_W-1:0]   yData_q, yData_d;
  logic [CLS_W-1:0]            class_q, class_d;

  logic signed [PROD_W-1:0]    prod [NUM_OUT];
  logic signed [ACC_W-1:0]     sum  [NUM_OUT];
  logic signed [ACC_W-1:0]     rs   [NUM_OUT];
  logic signed [DATA_W-1:0]    res  [NUM_OUT];
  logic signed [DATA_W-1:0]    bestVal;
  logic [CLS_W-1:0]            bestIdx;

  always_comb begin
    for (int n = 0; n < NUM_OUT; n++) begin
      prod[n] = PROD_W'($signed(x_data_i)) * PROD_W'($signed(w_data_i[n*DATA_W +: DATA_W]));
    end
  end

  // Bias is aligned to the accumulator's binary point before the rescale shift.
  always_comb begin
    for (int n = 0; n < NUM_OUT; n++) begin
      sum[n] = acc_q[n] + ({{(ACC_W-DATA_W){bias_q[n*DATA_W+DATA_W-1]}}, bias_q[n*DATA_W +: DATA_W]} << FRAC_W);
      rs[n]  = sum[n] >>> FRAC_W;
      if (rs[n] > SAT_MAX) begin
        res[n] = SAT_MAX[DATA_W-1:0];
      end else if (rs[n] < SAT_MIN) begin
        res[n] = SAT_MIN[DATA_W-1:0];
      end else begin
        res[n] = rs[n][DATA_W-1:0];
      end
      if (reluEn_q && (res[n] < 0)) begin
        res[n] = '0;
      end
    end
    bestIdx = '0;
    bestVal = res[0];
    for (int n = 1; n < NUM_OUT; n++) begin
      if (res[n] > bestVal) begin
        bestVal = res[n];
        bestIdx = CLS_W'(n);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    bias_d   = bias_q;
    reluEn_d = reluEn_q;
    yData_d  = yData_q;
    class_d  = class_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          bias_d   = bias_i;
          reluEn_d = relu_en_i;
          cnt_d    = '0;
          for (int n = 0; n < NUM_OUT; n++) acc_d[n] = '0;
          state_d  = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (x_valid_i) begin
          for (int n = 0; n < NUM_OUT; n++) begin
            acc_d[n] = acc_q[n] + {{(ACC_W-PROD_W){prod[n][PROD_W-1]}}, prod[n]};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(NUM_IN - 1)) state_d = S_FINAL;
        end
      end
      S_FINAL: begin
        for (int n = 0; n < NUM_OUT; n++) yData_d[n*DATA_W +: DATA_W] = res[n];
        class_d = bestIdx;
        state_d = S_OUTPUT;
      end
      S_OUTPUT: begin
        if (y_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      for (int n = 0; n < NUM_OUT; n++) acc_q[n] <= '0;
      bias_q   <= '0;
      reluEn_q <= 1'b0;
      yData_q  <= '0;
      class_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      for (int n = 0; n < NUM_OUT; n++) acc_q[n] <= acc_d[n];
      bias_q   <= bias_d;
      reluEn_q <= reluEn_d;
      yData_q  <= yData_d;
      class_q  <= class_d;
    end
  end

  assign x_ready_o  = (state_q == S_ACCUM);
  assign y_valid_o  = (state_q == S_OUTPUT);
  assign busy_o     = (state_q != S_IDLE);
  assign y_data_o   = yData_q;
  assign class_id_o = class_q;

endmodule
